ringbuffer_arbiter: RTL and testbench

RINGBUFFER_ARBITER -- requirements
Module: ringbuffer_arbiter

---
 rtl/ringbuffer_arbiter_pkg.sv | 16 +
 rtl/ringbuffer_arbiter_rr_pick.sv | 30 +++
 rtl/ringbuffer_arbiter.sv | 129 ++++++++++++
 tb/tb_ringbuffer_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ringbuffer_arbiter_pkg.sv
// Shared definitions for the ringbuffer family: the arbiter FSM state
// encoding and a helper for sizing counters.
package ringbuffer_arbiter_pkg;

    // Two-state drain FSM, encoded IDLE=0 and BURST=1.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rb_state_e;

    // Width of a counter that must hold 0..depth-1, never less than one bit.
    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ringbuffer_arbiter_rr_pick.sv
// Round-robin picker: scans the request vector starting one slot after
// the last granted index, wrapping modulo N, and reports the first hit.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [IW-1:0] o_grant,
    output logic          o_valid
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin : p_pick
        int idx;
        // NOTE: every output gets a default before the loop; a path that
        // leaves a combinational output unassigned would infer a latch.
        o_grant = '0;
        o_valid = 1'b0;
        idx     = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(i_last) + k) % N;
            if (i_req[idx]) begin
                o_grant = IW'(idx);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ringbuffer_arbiter.sv
// Drains several upstream ringbuffers into one ready/valid stream. Urgent
// (half-full) channels win over merely non-empty ones; ties rotate
// round-robin. Each grant forwards up to BURST words, then re-arbitrates.
module ringbuffer_arbiter
    import ringbuffer_arbiter_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int BURST    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [CHANNELS-1:0]         ch_empty,
    input  logic [CHANNELS-1:0]         ch_half_full,
    input  logic [CHANNELS*WIDTH-1:0]   ch_data,
    output logic [CHANNELS-1:0]         ch_pop,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [$clog2(CHANNELS)-1:0] out_channel,
    output logic                        out_first,
    output logic                        busy
);

    localparam int             IW       = $clog2(CHANNELS);
    localparam int             CW       = cnt_width(BURST);
    localparam logic [CW-1:0]  LAST_CNT = CW'(BURST - 1);

    rb_state_e              r_state, w_state_nxt;
    logic [IW-1:0]          r_sel, w_sel_nxt;
    logic [IW-1:0]          r_last_grant, w_last_grant_nxt;
    logic [CW-1:0]          r_count, w_count_nxt;

    logic [CHANNELS-1:0]    w_urgent_req;
    logic [CHANNELS-1:0]    w_normal_req;
    logic [IW-1:0]          w_urgent_grant;
    logic [IW-1:0]          w_normal_grant;
    logic                   w_urgent_any;
    logic                   w_normal_any;
    logic [IW-1:0]          w_pick;
    logic                   w_sel_empty;
    logic                   w_transfer;

    assign w_normal_req = ~ch_empty;
    assign w_urgent_req = ch_half_full & ~ch_empty;

    rr_pick #(.N(CHANNELS), .IW(IW)) u_pick_urgent (
        .i_req   (w_urgent_req),
        .i_last  (r_last_grant),
        .o_grant (w_urgent_grant),
        .o_valid (w_urgent_any)
    );

    rr_pick #(.N(CHANNELS), .IW(IW)) u_pick_normal (
        .i_req   (w_normal_req),
        .i_last  (r_last_grant),
        .o_grant (w_normal_grant),
        .o_valid (w_normal_any)
    );

    // Urgent class takes precedence; the normal class is a superset, so
    // "any urgent" implies "any normal".
    assign w_pick      = w_urgent_any ? w_urgent_grant : w_normal_grant;

    // The datapath is a pure mux on the granted channel: no added latency,
    // and an asynchronous reset drops valid/pop in the same cycle.
    assign w_sel_empty = ch_empty[r_sel];
    assign busy        = (r_state == ST_BURST);
    assign out_valid   = busy & ~w_sel_empty;
    assign w_transfer  = out_valid & out_ready;
    assign out_data    = ch_data[r_sel*WIDTH +: WIDTH];
    assign out_channel = r_sel;
    assign out_first   = out_valid & (r_count == '0);

    // Pop strobe only on the granted channel, only on an accepted word.
    always_comb begin
        ch_pop        = '0;
        ch_pop[r_sel] = w_transfer;
    end

    // Next-state logic: grant in IDLE, count and terminate in BURST.
    always_comb begin
        w_state_nxt      = r_state;
        w_sel_nxt        = r_sel;
        w_last_grant_nxt = r_last_grant;
        w_count_nxt      = r_count;
        case (r_state)
            ST_IDLE: begin
                if (en && w_normal_any) begin
                    w_state_nxt      = ST_BURST;
                    w_sel_nxt        = w_pick;
                    w_last_grant_nxt = w_pick;
                    w_count_nxt      = '0;
                end
            end
            ST_BURST: begin
                if (w_sel_empty) begin
                    // Source ran dry: give the bus back rather than wait.
                    w_state_nxt = ST_IDLE;
                end else if (w_transfer) begin
                    w_count_nxt = r_count + 1'b1;
                    if (r_count == LAST_CNT) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State registers; reset primes last_grant so channel 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments here so every register samples
        // the pre-edge values regardless of statement order.
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sel        <= '0;
            r_last_grant <= IW'(CHANNELS - 1);
            r_count      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_count      <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_ringbuffer_arbiter.sv
// Self-checking bench for ringbuffer_arbiter. A queue per channel models
// the upstream ringbuffers; expected transfers go into a scoreboard when
// data is loaded and are compared as the DUT forwards words.
module tb_ringbuffer_arbiter;

    localparam int CH    = 4;
    localparam int W     = 8;
    localparam int BURST = 16;
    localparam int IW    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [CH-1:0]     ch_empty;
    logic [CH-1:0]     ch_half_full;
    logic [CH*W-1:0]   ch_data;
    logic [CH-1:0]     ch_pop;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [IW-1:0]     out_channel;
    logic              out_first;
    logic              busy;

    typedef struct packed {
        logic [IW-1:0] ch;
        logic [W-1:0]  data;
        logic          first;
    } exp_t;

    exp_t          sb[$];
    logic [W-1:0]  fifo[CH][$];
    logic [CH-1:0] hf;
    logic [CH-1:0] pend_pop;
    logic [3:0]    ready_pat;
    logic          ready_mode;
    int            vectors;
    int            miscompares;
    int            cyc;
    int            xfers;
    int            xfer_cyc[$];

    always #5 clk = ~clk;

    ringbuffer_arbiter #(.CHANNELS(CH), .WIDTH(W), .BURST(BURST)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .ch_empty     (ch_empty),
        .ch_half_full (ch_half_full),
        .ch_data      (ch_data),
        .ch_pop       (ch_pop),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_channel  (out_channel),
        .out_first    (out_first),
        .busy         (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive the ringbuffer flags/head words from the queue models.
    task automatic refresh();
        for (int i = 0; i < CH; i++) begin
            ch_empty[i]         = (fifo[i].size() == 0);
            ch_half_full[i]     = hf[i];
            ch_data[i*W +: W]   = (fifo[i].size() != 0) ? fifo[i][0] : '0;
        end
    endtask

    function automatic logic fifos_empty();
        logic e;
        e = 1'b1;
        for (int i = 0; i < CH; i++) if (fifo[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic load(input int c, input int n);
        for (int k = 0; k < n; k++) fifo[c].push_back(W'((c << 6) | k));
        refresh();
    endtask

    task automatic expect_burst(input int c, input int start, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.ch    = IW'(c);
            e.data  = W'((c << 6) | (start + k));
            e.first = (k == 0);
            sb.push_back(e);
        end
    endtask

    // One clock: monitor at negedge, then apply pops and new inputs just
    // after the posedge so the DUT always sees stable inputs.
    task automatic cycle();
        exp_t          e;
        logic [CH-1:0] exp_pop;
        @(negedge clk);
        cyc++;
        exp_pop = '0;
        if (out_valid && out_ready) begin
            xfers++;
            xfer_cyc.push_back(cyc);
            check_eq("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("out_channel", 32'(out_channel), 32'(e.ch));
                check_eq("out_data", 32'(out_data), 32'(e.data));
                check_eq("out_first", 32'(out_first), 32'(e.first));
                exp_pop = CH'(1) << e.ch;
            end
        end
        check_eq("ch_pop", 32'(ch_pop), 32'(exp_pop));
        pend_pop = ch_pop;
        @(posedge clk);
        #1;
        for (int i = 0; i < CH; i++)
            if (pend_pop[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
        if (ready_mode) out_ready = ready_pat[cyc % 4];
        refresh();
    endtask

    task automatic settle();
        repeat (3) cycle();
        check_eq("idle_after", 32'(busy), 32'd0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || !fifos_empty()) && n < budget) begin
            cycle();
            n++;
        end
        check_eq("drain_in_budget", 32'(n < budget), 32'd1);
        settle();
    endtask

    task automatic run_until_xfers(input int target, input int budget);
        int n;
        n = 0;
        while (xfers < target && n < budget) begin
            cycle();
            n++;
        end
        check_eq("xfer_in_budget", 32'(n < budget), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int c0;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        xfers       = 0;
        hf          = '0;
        pend_pop    = '0;
        ready_pat   = 4'b1001;
        ready_mode  = 1'b0;
        out_ready   = 1'b1;
        en          = 1'b1;
        rst         = 1'b1;
        refresh();

        // Reset takes effect before any clock edge.
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_pop", 32'(ch_pop), 32'd0);
        check_eq("rst_channel", 32'(out_channel), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 20 words on ch0: 16-word burst, one IDLE cycle, then 4 words.
        base = xfer_cyc.size();
        c0   = cyc;
        load(0, 20);
        expect_burst(0, 0, 16);
        expect_burst(0, 16, 4);
        drain(100);
        check_eq("t1_count", 32'(xfer_cyc.size() - base), 32'd20);
        if (xfer_cyc.size() - base == 20) begin
            check_eq("t1_latency", 32'(xfer_cyc[base] - c0), 32'd2);
            check_eq("t1_burst_span", 32'(xfer_cyc[base+15] - xfer_cyc[base]), 32'd15);
            check_eq("t1_rearb_gap", 32'(xfer_cyc[base+16] - xfer_cyc[base+15]), 32'd2);
        end

        // ch1 and ch3 both loaded: bursts alternate ch1, ch3, ch1, ch3.
        load(1, 20);
        load(3, 20);
        expect_burst(1, 0, 16);
        expect_burst(3, 0, 16);
        expect_burst(1, 16, 4);
        expect_burst(3, 16, 4);
        drain(200);

        // Half-full ch2 beats ch0 even though ch0 is next in rotation.
        hf[2] = 1'b1;
        load(0, 3);
        load(2, 3);
        expect_burst(2, 0, 3);
        expect_burst(0, 0, 3);
        drain(100);
        hf = '0;
        refresh();

        // Backpressure 1,0,0,1 and en dropped mid-burst.
        ready_mode = 1'b1;
        base = xfers;
        load(1, 6);
        expect_burst(1, 0, 6);
        run_until_xfers(base + 2, 40);
        en = 1'b0;
        drain(100);
        ready_mode = 1'b0;
        out_ready  = 1'b1;

        // With en low, a waiting channel is not granted.
        load(3, 1);
        expect_burst(3, 0, 1);
        repeat (5) cycle();
        check_eq("en_blocks_busy", 32'(busy), 32'd0);
        check_eq("en_blocks_sb", 32'(sb.size()), 32'd1);
        en = 1'b1;
        drain(50);

        // ch0 runs dry after 3 words; ch1 takes over.
        base = xfer_cyc.size();
        load(0, 3);
        load(1, 2);
        expect_burst(0, 0, 3);
        expect_burst(1, 0, 2);
        drain(100);
        check_eq("t5_count", 32'(xfer_cyc.size() - base), 32'd5);
        if (xfer_cyc.size() - base == 5) begin
            check_eq("t5_handover_gap", 32'(xfer_cyc[base+3] - xfer_cyc[base+2]), 32'd3);
        end

        // Reset while ch2 presents word 5: valid and pop drop at once,
        // ch0 wins next, then ch2 resumes at word 5 with nothing lost.
        base = xfers;
        load(2, 10);
        expect_burst(2, 0, 5);
        run_until_xfers(base + 5, 40);
        rst = 1'b1;
        #1;
        check_eq("midrst_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_pop", 32'(ch_pop), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        load(0, 2);
        expect_burst(0, 0, 2);
        expect_burst(2, 5, 5);
        cycle();
        rst = 1'b0;
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
